wb_mem_responder: RTL and testbench

Wishbone-classic memory responder: the target end of the instruction/data bus the load/store unit drives. It accepts single-beat read/write cycles, applies a configurable number of wait states, performs byte-enabled writes into an internal word array, and returns data with a one-cycle `ack_o` (or `err_o`). It stands in for instruction and data memory in simulation and small FPGA builds.

---
 rtl/titan_wb_pkg.sv | 16 +
 rtl/wb_mem_array.sv | 29 ++
 rtl/wb_mem_responder.sv | 130 +++++++++++++
 tb/tb_wb_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/titan_wb_pkg.sv
// Shared Wishbone widths and responder FSM encoding.
// Imported by wb_mem_responder and wb_mem_array.
package titan_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WCNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_state_e;

endpackage

// File: rtl/wb_mem_array.sv
// Byte-enabled single-port synchronous RAM, 2^ADDR_WIDTH x 32.
// Read data is registered; contents are never reset.
module wb_mem_array
  import titan_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WB_SEL_W-1:0]   be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DAT_W-1:0]   wdata,
  output logic [WB_DAT_W-1:0]   rdata
);

  logic [WB_DAT_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone-classic memory responder with configurable wait states.
// Define WB_RESP_ERR_EN to terminate misaligned/out-of-range requests with err_o.
module wb_mem_responder
  import titan_wb_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 10,
  parameter int                  WAIT_STATES = 1,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WB_ADR_W-1:0] adr_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic                we_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic [WB_DAT_W-1:0] dat_o,
  output logic                ack_o,
  output logic                err_o
);

  localparam logic [WCNT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? '0 : WCNT_W'(WAIT_STATES - 1);

  wb_state_e state;
  wb_state_e state_nx;

  logic [WCNT_W-1:0]     cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WB_DAT_W-1:0]   dat_q;
  logic [WB_DAT_W-1:0]   wdata;
  logic [WB_DAT_W-1:0]   rdata;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [WB_SEL_W-1:0]   be;
  logic                  we_q;
  logic                  bad_q;
  logic                  bad_in;
  logic                  req;
  logic                  live;
  logic                  we_eff;
  logic                  bad_eff;
  logic                  ram_we;

  assign req  = cyc_i & stb_i;
  assign live = (state == IDLE);

  // With zero wait states the array is accessed on the capture edge itself
  assign idx     = live ? adr_i[ADDR_WIDTH+1:2] : idx_q;
  assign wdata   = live ? dat_i  : dat_q;
  assign be      = live ? sel_i  : sel_q;
  assign we_eff  = live ? we_i   : we_q;
  assign bad_eff = live ? bad_in : bad_q;
  assign ram_we  = (state_nx == RESP) & we_eff & ~bad_eff;

`ifdef WB_RESP_ERR_EN
  logic [WB_ADR_W-1:0] off;
  assign off    = adr_i - BASE_ADDR;
  assign bad_in = (adr_i[1:0] != 2'b00)
                | ((off >> (ADDR_WIDTH + 2)) != '0);
  assign ack_o  = (state == RESP) & ~bad_q;
  assign err_o  = (state == RESP) & bad_q;
`else
  logic unused_adr;
  assign unused_adr = ^{adr_i[1:0],
                        adr_i[WB_ADR_W-1:ADDR_WIDTH+2]};
  assign bad_in = 1'b0;
  assign ack_o  = (state == RESP);
  assign err_o  = 1'b0;
`endif

  assign dat_o = (ack_o & ~we_q) ? rdata : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (live && req) begin
        idx_q <= adr_i[ADDR_WIDTH+1:2];
        dat_q <= dat_i;
        sel_q <= sel_i;
        we_q  <= we_i;
        bad_q <= bad_in;
        cnt   <= WS_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  wb_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .addr (idx),
    .wdata(wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (1, 3 and 0 wait states),
// directed table, corner sequences and a randomized run against a word model.
module tb_wb_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr [N];
  logic [31:0] dat [N];
  logic [3:0]  sel [N];
  logic        we  [N];
  logic        cyc [N];
  logic        stb [N];
  logic [31:0] rd  [N];
  logic        ack [N];
  logic        err [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .adr_i(adr[0]), .dat_i(dat[0]),
    .sel_i(sel[0]), .we_i(we[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
    .dat_o(rd[0]), .ack_o(ack[0]), .err_o(err[0]));

  wb_mem_responder #(.WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .adr_i(adr[1]), .dat_i(dat[1]),
    .sel_i(sel[1]), .we_i(we[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
    .dat_o(rd[1]), .ack_o(ack[1]), .err_o(err[1]));

  wb_mem_responder #(.WAIT_STATES(0)) u2 (
    .clk(clk), .rst(rst), .adr_i(adr[2]), .dat_i(dat[2]),
    .sel_i(sel[2]), .we_i(we[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
    .dat_o(rd[2]), .ack_o(ack[2]), .err_o(err[2]));

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [11];

  logic [31:0] mdl [int];

  function automatic int ws_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_bad(input logic [31:0] a);
`ifdef WB_RESP_ERR_EN
    return (a % 4 != 0) || (a >= 32'h1000);
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    return k * 1024 + int'((a / 4) % 1024);
  endfunction

  function automatic vec_t mk(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] e);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_write(input int k, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    logic [31:0] word;
    int kk;
    kk = key(k, a);
    word = mdl.exists(kk) ? mdl[kk] : 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) word[8*i +: 8] = d[8*i +: 8];
    end
    mdl[kk] = word;
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; dat[k] = '0; sel[k] = '0;
    end
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input bit scr, output logic ak, output logic er,
                     output logic [31:0] dt, output int lat);
    @(negedge clk);
    adr[k] = a; dat[k] = d; sel[k] = s; we[k] = w;
    cyc[k] = 1'b1; stb[k] = 1'b1;
    @(posedge clk); #1;
    if (scr) begin
      adr[k] = $urandom; dat[k] = $urandom;
      sel[k] = 4'($urandom); we[k] = 1'($urandom);
    end
    lat = -1; ak = 1'b0; er = 1'b0; dt = '0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (ack[k] || err[k]) begin
        lat = n; ak = ack[k]; er = err[k]; dt = rd[k];
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("k%0d_pulse_end_%h", k, a),
        {rd[k][31:2], ack[k], err[k]}, 32'h0);
  endtask

  task automatic run(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input bit scr, input logic [31:0] exp_dat);
    bit bad;
    logic ak, er;
    logic [31:0] dt;
    int lat;
    bad = exp_bad(a);
    txn(k, w, a, d, s, scr, ak, er, dt, lat);
    chk($sformatf("k%0d_lat_%h", k, a), 32'(lat), 32'(ws_of(k)));
    chk($sformatf("k%0d_ack_%h", k, a), 32'(ak), 32'(!bad));
    chk($sformatf("k%0d_err_%h", k, a), 32'(er), 32'(bad));
    if (!w || bad) begin
      chk($sformatf("k%0d_dat_%h", k, a), dt, bad ? 32'h0 : exp_dat);
    end
    if (w && !bad) model_write(k, a, d, s);
  endtask

  task automatic quiet(input int k, input int cycles, input string nm);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("k%0d_%s_%0d", k, nm, i),
          {rd[k][31:2], ack[k], err[k]}, 32'h0);
    end
  endtask

  initial begin
    vt[0]  = mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
    vt[1]  = mk(0, 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF);
    vt[2]  = mk(1, 32'h20, 32'h1122_3344, 4'hF, 32'h0);
    vt[3]  = mk(1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h0);
    vt[4]  = mk(0, 32'h20, 32'h0,         4'h0, 32'h11BB_33DD);
    vt[5]  = mk(1, 32'h24, 32'h5566_7788, 4'hF, 32'h0);
    vt[6]  = mk(1, 32'h24, 32'hFFFF_FFFF, 4'h0, 32'h0);
    vt[7]  = mk(0, 32'h24, 32'h0,         4'h3, 32'h5566_7788);
    vt[8]  = mk(1, 32'h30, 32'h3030_3030, 4'hF, 32'h0);
    vt[9]  = mk(1, 32'h40, 32'h4040_4040, 4'hF, 32'h0);
    vt[10] = mk(0, 32'h40, 32'h0,         4'hF, 32'h4040_4040);

    idle_all();
    for (int k = 0; k < N; k++) begin
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; sel[k] = 4'hF;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("k%0d_reset_%0d", k, c),
            {rd[k][31:2], ack[k], err[k]}, 32'h0);
      end
    end
    idle_all();
    rst = 1'b1;

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 11; i++) begin
        run(k, vt[i].w, vt[i].a, vt[i].d, vt[i].s, 1'b0, vt[i].exp);
      end
    end

    // abort: drop cyc during the second wait cycle of a 3-wait write
    @(negedge clk);
    adr[1] = 32'h30; dat[1] = 32'h0BAD_F00D; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    quiet(1, 8, "abort_quiet");
    run(1, 0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h3030_3030);

    // reset during the wait phase of a write
    @(negedge clk);
    adr[1] = 32'h40; dat[1] = 32'h9999_9999; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    quiet(1, 3, "rst_hold");
    rst = 1'b1;
    quiet(1, 5, "rst_after");
    run(1, 0, 32'h40, 32'h0, 4'hF, 1'b0, 32'h4040_4040);

`ifdef WB_RESP_ERR_EN
    run(0, 0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 32'h0);
    run(0, 1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    run(0, 1, 32'h0000_0002, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    run(0, 0, 32'h0, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D);
    run(2, 0, 32'h0000_0FFF, 32'h0, 4'hF, 1'b0, 32'h0);
`else
    run(0, 0, 32'h0000_1010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
    run(2, 0, 32'hFFFF_F022, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD);
`endif

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
        int          kk;
        a = 32'h400 + 4 * $urandom_range(0, 7);
        if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
        if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
        d = $urandom;
        s = 4'($urandom);
        w = 1'($urandom);
        kk = key(k, a);
        if (!mdl.exists(kk) && !exp_bad(a)) begin
          w = 1'b1;
          s = 4'hF;
        end
        run(k, w, a, d, s, 1'b1, mdl.exists(kk) ? mdl[kk] : 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
